// File: rtl/clock_display_scan.sv
// clock_display_scan: scans a 6-digit common-anode 7-segment display (HH.MM.SS)
// from the binary time-of-day counter. One snapshot of hour/min/sec is taken per
// frame, so the digits of a frame always belong to the same instant.
`timescale 1ns/1ps

module clock_display_scan #(
    parameter int HOUR_W   = 3,
    parameter int MIN_W    = 4,
    parameter int SEC_W    = 5,
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [HOUR_W-1:0] hour,
    input  logic [MIN_W-1:0]  min,
    input  logic [SEC_W-1:0]  sec,
    output logic [5:0]        an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              snap_stb
);

    localparam int             DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]     LAST_IDX = 3'd5;

    // Scan state and frame snapshot
    logic             r_valid;
    logic [2:0]       r_idx;
    logic [DIV_W-1:0] r_div_cnt;
    logic [5:0]       r_snap_hour;
    logic [5:0]       r_snap_min;
    logic [5:0]       r_snap_sec;

    // Registered display outputs
    logic [5:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_snap_stb;

    // Decode of the digit currently addressed by r_idx
    logic [5:0]       w_field;
    logic [2:0]       w_tens;
    logic [5:0]       w_ones;
    logic [5:0]       w_digit;
    logic [6:0]       w_seg;
    logic             w_blank;

    // Select the snapshot field for the current digit and split it into tens/ones
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_field = r_snap_hour;
        case (r_idx[2:1])
            2'd0:    w_field = r_snap_sec;
            2'd1:    w_field = r_snap_min;
            default: w_field = r_snap_hour;
        endcase

        // Field values are at most 63, so the tens digit is found by a short compare chain.
        if      (w_field >= 6'd60) w_tens = 3'd6;
        else if (w_field >= 6'd50) w_tens = 3'd5;
        else if (w_field >= 6'd40) w_tens = 3'd4;
        else if (w_field >= 6'd30) w_tens = 3'd3;
        else if (w_field >= 6'd20) w_tens = 3'd2;
        else if (w_field >= 6'd10) w_tens = 3'd1;
        else                       w_tens = 3'd0;

        w_ones  = w_field - (6'(w_tens) * 6'd10);
        w_digit = r_idx[0] ? 6'(w_tens) : w_ones;

        // Leading-zero blanking applies only to the hour tens digit.
        w_blank = BLANK_LZ && (r_idx == LAST_IDX) && (w_tens == 3'd0);
    end

    // Decimal digit to active-low segment pattern {g,f,e,d,c,b,a}
    always_comb begin
        w_seg = 7'h7F;
        case (w_digit)
            6'd0:    w_seg = 7'h40;
            6'd1:    w_seg = 7'h79;
            6'd2:    w_seg = 7'h24;
            6'd3:    w_seg = 7'h30;
            6'd4:    w_seg = 7'h19;
            6'd5:    w_seg = 7'h12;
            6'd6:    w_seg = 7'h02;
            6'd7:    w_seg = 7'h78;
            6'd8:    w_seg = 7'h00;
            6'd9:    w_seg = 7'h10;
            default: w_seg = 7'h7F;
        endcase
    end

    // Scan sequencing, frame snapshot and registered display drive
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // here sees the pre-edge values of the others, independent of statement order.
        if (!rstn) begin
            r_valid     <= 1'b0;
            r_idx       <= 3'd0;
            r_div_cnt   <= '0;
            r_snap_hour <= 6'd0;
            r_snap_min  <= 6'd0;
            r_snap_sec  <= 6'd0;
            r_an        <= 6'h3F;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
            r_snap_stb  <= 1'b0;
        end else if (!r_valid) begin
            // First edge out of reset: capture the time, display stays dark.
            r_valid     <= 1'b1;
            r_snap_hour <= 6'(hour);
            r_snap_min  <= 6'(min);
            r_snap_sec  <= 6'(sec);
            r_snap_stb  <= 1'b1;
            r_an        <= 6'h3F;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
        end else begin
            if (w_blank) begin
                r_an  <= 6'h3F;
                r_seg <= 7'h7F;
            end else begin
                r_an  <= ~(6'b000001 << r_idx);
                r_seg <= w_seg;
            end
            r_dp       <= !((r_idx == 3'd2) || (r_idx == 3'd4));
            r_snap_stb <= 1'b0;

            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
                if (r_idx == LAST_IDX) begin
                    // Frame wrap: the next frame starts from a fresh snapshot.
                    r_idx       <= 3'd0;
                    r_snap_hour <= 6'(hour);
                    r_snap_min  <= 6'(min);
                    r_snap_sec  <= 6'(sec);
                    r_snap_stb  <= 1'b1;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    assign an       = r_an;
    assign seg      = r_seg;
    assign dp       = r_dp;
    assign snap_stb = r_snap_stb;

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan. Two instances with different
// parameters share one stimulus stream; a timeline model predicts each edge's
// outputs into per-instance queues, and a monitor pops and compares them.
`timescale 1ns/1ps

module tb_clock_display_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [5:0] hour, min, sec;

    logic [5:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, stb_a, stb_b;

    // Instance A: default widths, SCAN_DIV=4, leading-zero blanking on
    clock_display_scan #(
        .HOUR_W(3), .MIN_W(4), .SEC_W(5), .SCAN_DIV(4), .BLANK_LZ(1'b1)
    ) dut_a (
        .clk(clk), .rstn(rstn),
        .hour(hour[2:0]), .min(min[3:0]), .sec(sec[4:0]),
        .an(an_a), .seg(seg_a), .dp(dp_a), .snap_stb(stb_a)
    );

    // Instance B: full 6-bit fields, SCAN_DIV=3, no blanking
    clock_display_scan #(
        .HOUR_W(6), .MIN_W(6), .SEC_W(6), .SCAN_DIV(3), .BLANK_LZ(1'b0)
    ) dut_b (
        .clk(clk), .rstn(rstn),
        .hour(hour), .min(min), .sec(sec),
        .an(an_b), .seg(seg_b), .dp(dp_b), .snap_stb(stb_b)
    );

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       stb;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release and the frame snapshot
    int t_cnt[2];
    int snap_h[2], snap_m[2], snap_s[2];
    int sd[2]    = '{4, 3};
    bit blz[2]   = '{1'b1, 1'b0};
    logic [6:0] seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Timeline model: edge E0 snapshots, then digit (k mod frame)/SCAN_DIV is shown
    function automatic exp_t model_step(int d, bit r, int h, int m, int s);
        exp_t e;
        int fr, k, digit, val;
        e.an  = 6'h3F;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.stb = 1'b0;
        fr = 6 * sd[d];
        if (!r) begin
            t_cnt[d] = 0;
        end else if (t_cnt[d] == 0) begin
            e.stb = 1'b1;
            snap_h[d] = h; snap_m[d] = m; snap_s[d] = s;
            t_cnt[d] = 1;
        end else begin
            k     = t_cnt[d] - 1;
            digit = (k % fr) / sd[d];
            if (digit < 2)      val = snap_s[d];
            else if (digit < 4) val = snap_m[d];
            else                val = snap_h[d];
            val = (digit % 2 == 1) ? val / 10 : val % 10;
            if (!(digit == 5 && blz[d] && (snap_h[d] / 10) == 0)) begin
                e.an  = ~(6'b000001 << digit);
                e.seg = seg_tab[val];
            end
            e.dp = (digit == 2 || digit == 4) ? 1'b0 : 1'b1;
            if (t_cnt[d] % fr == 0) begin
                e.stb = 1'b1;
                snap_h[d] = h; snap_m[d] = m; snap_s[d] = s;
            end
            t_cnt[d] = t_cnt[d] + 1;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and record the expected result of that edge
    task automatic cycle(input bit r, input int h, input int m, input int s);
        @(negedge clk);
        rstn = r;
        hour = h[5:0];
        min  = m[5:0];
        sec  = s[5:0];
        @(posedge clk);
        q_a.push_back(model_step(0, r, h & 7, m & 15, s & 31));
        q_b.push_back(model_step(1, r, h, m, s));
    endtask

    // Monitor: compare DUT outputs shortly after each edge against queued expectations
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a_an",  {2'b0, an_a},  {2'b0, e.an});
                check("a_seg", {1'b0, seg_a}, {1'b0, e.seg});
                check("a_dp",  {7'b0, dp_a},  {7'b0, e.dp});
                check("a_stb", {7'b0, stb_a}, {7'b0, e.stb});
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_an",  {2'b0, an_b},  {2'b0, e.an});
                check("b_seg", {1'b0, seg_b}, {1'b0, e.seg});
                check("b_dp",  {7'b0, dp_b},  {7'b0, e.dp});
                check("b_stb", {7'b0, stb_b}, {7'b0, e.stb});
            end
        end
    end

    initial begin
        int h, m, s;
        rstn = 1'b0;
        hour = '0;
        min  = '0;
        sec  = '0;
        t_cnt = '{0, 0};

        // Held reset
        repeat (3) cycle(1'b0, 5, 12, 27);

        // Release with 05:12:27, then bump seconds mid-frame
        repeat (14) cycle(1'b1, 5, 12, 27);
        repeat (40) cycle(1'b1, 5, 12, 28);

        // 07:15:31 and a double-digit hour for the wide instance
        repeat (60) cycle(1'b1, 7, 15, 31);
        repeat (40) cycle(1'b1, 23, 59, 48);

        // Single-cycle reset in the middle of a frame
        repeat (13) cycle(1'b1, 19, 46, 9);
        cycle(1'b0, 19, 46, 9);
        repeat (80) cycle(1'b1, 19, 46, 9);

        // Randomised inputs with occasional resets
        h = 0; m = 0; s = 0;
        repeat (800) begin
            if ($urandom_range(0, 3) == 0) begin
                h = int'($urandom_range(0, 63));
                m = int'($urandom_range(0, 63));
                s = int'($urandom_range(0, 63));
            end
            cycle(($urandom_range(0, 149) != 0), h, m, s);
        end

        @(negedge clk);
        check("queue_drained", 8'(q_a.size() + q_b.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
